// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles little-endian bytes into 32-bit
// words, writes them at consecutive word addresses and verifies a trailing XOR checksum.
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_stall,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_ready never depends on in_valid, and in_valid may toggle freely.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHK   = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] idx_q;
  logic [1:0]      byte_cnt;
  logic [23:0]     part_q;
  logic [31:0]     acc_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic            err_q;

  logic            bad_len;
  logic            accept;
  logic            last_byte;
  logic            last_word;
  logic [31:0]     full_word;

  assign bad_len   = (len == '0) || (len > (ADDR_W+1)'(DEPTH));
  assign in_ready  = (state == S_RECV) || (state == S_CHK);
  assign accept    = in_valid && in_ready;
  assign last_byte = accept && (byte_cnt == 2'd3);
  assign full_word = {in_data, part_q};
  assign last_word = (idx_q == (len_q - (ADDR_W+1)'(1)));

  assign cpu_stall = (state != S_IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    mem_we  = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_n = bad_len ? S_FIN : S_RECV;
      end
      S_RECV: begin
        if (last_byte) state_n = S_WRITE;
      end
      S_WRITE: begin
        mem_we  = 1'b1;
        state_n = last_word ? S_CHK : S_RECV;
      end
      S_CHK: begin
        if (last_byte) state_n = S_FIN;
      end
      S_FIN: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output address/data registers are only loaded on a completed program word,
  // so they hold steady outside WRITE and are never touched by checksum bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      idx_q    <= '0;
      byte_cnt <= 2'd0;
      part_q   <= 24'd0;
      acc_q    <= 32'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q    <= len;
            idx_q    <= '0;
            byte_cnt <= 2'd0;
            part_q   <= 24'd0;
            acc_q    <= 32'd0;
            err_q    <= bad_len;
          end
        end
        S_RECV, S_CHK: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: part_q[7:0]   <= in_data;
              2'd1: part_q[15:8]  <= in_data;
              2'd2: part_q[23:16] <= in_data;
              default: begin
                if (state == S_RECV) begin
                  wdata_q <= full_word;
                  addr_q  <= 32'(idx_q) << 2;
                end else begin
                  err_q   <= (full_word != acc_q);
                end
              end
            endcase
          end
        end
        S_WRITE: begin
          acc_q <= acc_q ^ wdata_q;
          idx_q <= idx_q + (ADDR_W+1)'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a reference model predicts writes and err,
// a monitor compares them as the loader presents them.
module tb_imem_loader;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   len;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_stall;
  logic              done;
  logic              err;
  logic [2:0]        dbg_state;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_stall(cpu_stall), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];
  logic        exp_err_q[$];
  logic [31:0] prog[$];
  logic [31:0] chk_word;
  int          vectors = 0;
  int          miscompares = 0;
  int          start_cyc = 0;
  int          done_cyc = 0;
  bit          done_seen = 0;
  bit          chk1_armed = 0;
  bit          exp_ready1 = 0;
  bit          prev_done = 0;
  logic [63:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL write: unexpected write %h@%h", mem_wdata, mem_addr);
        end else begin
          mon_e = exp_q.pop_front();
          check("write", {mem_addr, mem_wdata}, mon_e);
        end
      end
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
        if (exp_err_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL done: unexpected done pulse, got 1 expected 0");
        end else begin
          check("err_at_done", err, exp_err_q.pop_front());
        end
      end
      if (prev_done) check("stall_after_done", cpu_stall, 0);
      if (chk1_armed && cyc == start_cyc + 1) begin
        check("stall_c1", cpu_stall, 1);
        check("ready_c1", in_ready, exp_ready1);
        chk1_armed = 0;
      end
      prev_done = done;
    end else begin
      prev_done = 0;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] xor_prog();
    logic [31:0] x = 32'd0;
    foreach (prog[i]) x ^= prog[i];
    return x;
  endfunction

  task automatic expect_load(input int l);
    bit bad = (l == 0) || (l > DEPTH);
    if (!bad)
      for (int i = 0; i < l; i++) exp_q.push_back({32'(i * 4), prog[i]});
    exp_err_q.push_back(bad || (xor_prog() != chk_word));
  endtask

  // ---------------- drivers ----------------
  task automatic present(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) begin
      @(negedge clk);
      start    = 0;
      in_data  = 8'hEE;
      in_valid = !in_ready;   // junk offered only while the loader refuses it
    end
    @(negedge clk);
    start    = 0;
    in_valid = 1;
    in_data  = b;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      vectors++; miscompares++;
      $display("FAIL byte_timeout: in_ready got 0 expected 1");
    end
  endtask

  task automatic begin_load(input int l);
    @(negedge clk);
    start      = 1;
    len        = l[ADDR_W:0];
    in_valid   = 0;
    start_cyc  = cyc;
    done_seen  = 0;
    exp_ready1 = !((l == 0) || (l > DEPTH));
    chk1_armed = 1;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap, input bit fixed_gap);
    for (int k = 0; k < 4; k++)
      present(w[8*k +: 8], fixed_gap ? maxgap : $urandom_range(0, maxgap));
  endtask

  task automatic run_load(input int l, input int maxgap, input bit fixed_gap,
                          input bit glitch, input bit timing);
    int n = 0;
    bit bad = (l == 0) || (l > DEPTH);
    expect_load(l);
    begin_load(l);
    if (!bad) begin
      for (int w = 0; w < l; w++) begin
        for (int k = 0; k < 4; k++) begin
          present(prog[w][8*k +: 8], fixed_gap ? maxgap : $urandom_range(0, maxgap));
          if (glitch && w == 0 && k == 0) begin
            @(negedge clk);
            in_valid = 0;
            start    = 1;
            len      = 9'($urandom_range(1, 200));
          end
        end
      end
      send_word(chk_word, maxgap, fixed_gap);
      @(negedge clk);
      in_valid = 0;
    end else begin
      @(negedge clk);
      start = 0;
    end
    while (!done_seen && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done_seen) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout: done got 0 expected 1");
    end else if (bad) begin
      check("badlen_done_cycle", done_cyc - start_cyc, 1);
    end else if (timing) begin
      check("done_cycle", done_cyc - start_cyc, 5 * l + 5);
    end
    @(negedge clk);
    check("idle_after_load", cpu_stall, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_ready"},  in_ready,  0);
    check({tag, "_mem_we"},    mem_we,    0);
    check({tag, "_mem_addr"},  mem_addr,  0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_cpu_stall"}, cpu_stall, 0);
    check({tag, "_done"},      done,      0);
    check({tag, "_err"},       err,       0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1; start = 0; len = '0; in_valid = 0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 0;

    // Reference program with correct checksum, full-rate stream.
    prog = '{32'h00500093, 32'h00300113, 32'h002081B3};
    chk_word = 32'h00408033;
    run_load(3, 0, 0, 0, 1);

    // Same program, zero checksum: writes still occur, err flagged.
    chk_word = 32'h00000000;
    run_load(3, 0, 0, 0, 1);

    // Illegal lengths.
    run_load(0, 0, 0, 0, 0);
    run_load(257, 0, 0, 0, 0);

    // Single word with fixed 3-cycle gaps and junk offered during WRITE.
    prog = '{32'h00000013};
    chk_word = xor_prog();
    run_load(1, 3, 1, 0, 0);

    // Reset after two bytes of word 1; word 0 has already been written.
    prog = '{$urandom(), $urandom()};
    exp_q.push_back({32'h0, prog[0]});
    begin_load(2);
    send_word(prog[0], 0, 0);
    present(prog[1][7:0], 0);
    present(prog[1][15:8], 0);
    @(negedge clk);
    in_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_outputs_zero("midrst");
    prog = '{32'h123450B7};
    chk_word = xor_prog();
    run_load(1, 1, 0, 0, 0);

    // start pulsed during RECV is ignored.
    prog = '{$urandom(), $urandom(), $urandom()};
    chk_word = xor_prog();
    run_load(3, 0, 0, 1, 0);

    // Randomised loads, some with corrupted checksum.
    repeat (8) begin
      int l = $urandom_range(1, 6);
      prog.delete();
      for (int i = 0; i < l; i++) prog.push_back($urandom());
      chk_word = xor_prog();
      if ($urandom_range(0, 1) == 1) chk_word ^= (32'h1 << $urandom_range(0, 31));
      run_load(l, $urandom_range(0, 2), 0, 0, 0);
    end

    repeat (3) @(negedge clk);
    check("pending_writes", exp_q.size(), 0);
    check("pending_dones", exp_err_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
